counter_sweep_ctrl: RTL and testbench

- Sequencer for the N-bit up/down counter datapath (counter extended with count-enable and synchronous clear).
- Drives the counter's mod (direction), cnt_en and cnt_clr, and watches its q output.
- Produces a programmable triangle sweep: clear to 0, ramp up to hi, dwell, ramp down to lo, dwell, and repeat for n_sweeps sweeps or until stopped.
- Sits between the configuration/control logic and the counter instance.

---
 rtl/counter_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an up/down counter with enable and synchronous clear.
// It clears the counter, ramps it to hi, dwells, ramps it to lo, dwells, and repeats.
module counter_sweep_ctrl #(
  parameter int N  = 4,
  parameter int DW = 4,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  input  logic [DW-1:0] dwell,
  input  logic [SW-1:0] n_sweeps,
  input  logic [N-1:0]  q,
  output logic          mod,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweep_cnt,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    UP       = 3'd2,
    DWELL_HI = 3'd3,
    DOWN     = 3'd4,
    DWELL_LO = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t        state;
  logic [N-1:0]  lo_l;
  logic [N-1:0]  hi_l;
  logic [DW-1:0] dwell_l;
  logic [SW-1:0] n_sweeps_l;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] sweep_next;

  assign sweep_next = sweep_cnt + SW'(1);

  // Handshake: start is a one-cycle request sampled only in IDLE; stop is
  // sampled every cycle and has priority over start and over every transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lo_l       <= '0;
      hi_l       <= '0;
      dwell_l    <= '0;
      n_sweeps_l <= '0;
      dwell_cnt  <= '0;
      sweep_cnt  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE && stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              if (lo < hi) begin
                lo_l       <= lo;
                hi_l       <= hi;
                dwell_l    <= dwell;
                n_sweeps_l <= n_sweeps;
                sweep_cnt  <= '0;
                state      <= CLEAR;
              end else begin
                err <= 1'b1;
              end
            end
          end
          CLEAR: state <= UP;
          UP: begin
            if (q == hi_l) begin
              if (dwell_l == '0) begin
                state <= DOWN;
              end else begin
                dwell_cnt <= dwell_l;
                state     <= DWELL_HI;
              end
            end
          end
          DWELL_HI: begin
            if (dwell_cnt <= DW'(1)) state <= DOWN;
            else dwell_cnt <= dwell_cnt - DW'(1);
          end
          DOWN: begin
            if (q == lo_l) begin
              sweep_cnt <= sweep_next;
              if (n_sweeps_l != '0 && sweep_next == n_sweeps_l) begin
                state <= DONE;
                done  <= 1'b1;
              end else if (dwell_l == '0) begin
                state <= UP;
              end else begin
                dwell_cnt <= dwell_l;
                state     <= DWELL_LO;
              end
            end
          end
          DWELL_LO: begin
            if (dwell_cnt <= DW'(1)) state <= UP;
            else dwell_cnt <= dwell_cnt - DW'(1);
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Counter controls decode straight from state and q so a ramp stops on the bound itself.
  always_comb begin
    cnt_clr = (state == CLEAR);
    mod     = !(state == DWELL_HI || state == DOWN);
    cnt_en  = (state == UP && q != hi_l) || (state == DOWN && q != lo_l);
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural counter closes the loop, and a per-cycle
// trajectory built from the sweep rules is queued and compared by a separate monitor.
module tb_counter_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] dwell;
  logic [3:0] n_sweeps;
  logic [3:0] q;
  logic       mod;
  logic       cnt_en;
  logic       cnt_clr;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweep_cnt;
  logic [2:0] dbg_state;

  int total;
  int bad;
  logic [13:0] exp_q[$];
  logic [3:0]  m_q;
  logic [3:0]  m_sc;

  counter_sweep_ctrl #(.N(4), .DW(4), .SW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .dwell(dwell), .n_sweeps(n_sweeps), .q(q), .mod(mod), .cnt_en(cnt_en),
    .cnt_clr(cnt_clr), .busy(busy), .done(done), .err(err),
    .sweep_cnt(sweep_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // controlled counter datapath
  always @(posedge clk or negedge rst) begin
    if (!rst) q <= 4'd0;
    else if (cnt_clr) q <= 4'd0;
    else if (cnt_en) q <= mod ? q + 4'd1 : q - 4'd1;
  end

  // record layout: busy clr en mod done err q[3:0] sweep_cnt[3:0]
  function automatic logic [13:0] rec(input logic b, input logic c, input logic e,
                                      input logic m, input logic d, input logic r,
                                      input logic [3:0] qq, input logic [3:0] s);
    return {b, c, e, m, d, r, qq, s};
  endfunction

  task automatic push_idle(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(rec(0, 0, 0, 1, 0, 0, m_q, m_sc));
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Expected trajectory from the sweep rules. mode 1 marks the DOWN cycle where stop
  // is driven (sweep sc_mark, q poke_v); modes 2/3 mark the first-ramp UP cycle at poke_v.
  task automatic gen_run(input int l, input int h, input int d, input int n,
                         input int mode, input int sc_mark, input int poke_v,
                         output int pidx);
    int s;
    int sc;
    pidx = -1;
    exp_q.push_back(rec(0, 0, 0, 1, 0, 0, m_q, m_sc));
    if (l >= h) begin
      exp_q.push_back(rec(0, 0, 0, 1, 0, 1, m_q, m_sc));
      push_idle(2);
      return;
    end
    exp_q.push_back(rec(1, 1, 0, 1, 0, 0, m_q, 4'd0));
    s  = 0;
    sc = 0;
    forever begin
      for (int v = s; v <= h; v++) begin
        if ((mode == 2 || mode == 3) && sc == 0 && s == 0 && v == poke_v) pidx = exp_q.size();
        exp_q.push_back(rec(1, 0, v != h, 1, 0, 0, 4'(v), 4'(sc)));
      end
      for (int i = 0; i < d; i++) exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 4'(h), 4'(sc)));
      for (int v = h; v >= l; v--) begin
        if (mode == 1 && sc == sc_mark && v == poke_v) begin
          pidx = exp_q.size();
          exp_q.push_back(rec(1, 0, v != l, 0, 0, 0, 4'(v), 4'(sc)));
          m_q  = (v != l) ? 4'(v - 1) : 4'(v);
          m_sc = 4'(sc);
          push_idle(3);
          return;
        end
        exp_q.push_back(rec(1, 0, v != l, 0, 0, 0, 4'(v), 4'(sc)));
      end
      sc = (sc + 1) % 16;
      if (n != 0 && sc == n) begin
        exp_q.push_back(rec(1, 0, 0, 1, 1, 0, 4'(l), 4'(sc)));
        m_q  = 4'(l);
        m_sc = 4'(sc);
        push_idle(2);
        return;
      end
      for (int i = 0; i < d; i++) exp_q.push_back(rec(1, 0, 0, 1, 0, 0, 4'(l), 4'(sc)));
      s = l;
    end
  endtask

  // driver: one start request, optional mid-run poke, then drain the expected queue
  task automatic run(input int l, input int h, input int d, input int n,
                     input int mode, input int sc_mark, input int poke_v);
    int pidx;
    int k;
    @(posedge clk); #1;
    lo = 4'(l); hi = 4'(h); dwell = 4'(d); n_sweeps = 4'(n);
    gen_run(l, h, d, n, mode, sc_mark, poke_v, pidx);
    start = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      stop  = 1'b0;
      if (k == pidx) begin
        case (mode)
          1: stop = 1'b1;
          2: begin
            start = 1'b1;
            lo    = 4'($urandom_range(0, 15));
            hi    = 4'($urandom_range(0, 15));
          end
          3: begin
            #2 rst = 1'b0;
            exp_q.delete();
            #1;
            check("rst_busy", {3'd0, busy}, 4'd0);
            check("rst_en", {3'd0, cnt_en}, 4'd0);
            check("rst_clr", {3'd0, cnt_clr}, 4'd0);
            check("rst_mod", {3'd0, mod}, 4'd1);
            check("rst_done", {3'd0, done}, 4'd0);
            check("rst_err", {3'd0, err}, 4'd0);
            check("rst_sc", sweep_cnt, 4'd0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst  = 1'b1;
            m_q  = 4'd0;
            m_sc = 4'd0;
            push_idle(4);
          end
          default: ;
        endcase
      end
    end
    total++;
    if (k >= 2000) begin
      bad++;
      $display("FAIL drain: %0d records left after %0d cycles, want 0", exp_q.size(), k);
      exp_q.delete();
    end
  endtask

  task automatic start_stop_idle();
    @(posedge clk); #1;
    lo = 4'd2; hi = 4'd9; dwell = 4'd1; n_sweeps = 4'd1;
    start = 1'b1;
    stop  = 1'b1;
    push_idle(1);
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    push_idle(3);
    repeat (5) @(posedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [13:0] exp_r;
    logic [13:0] act_r;
    if (rst && exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      act_r = {busy, cnt_clr, cnt_en, mod, done, err, q, sweep_cnt};
      total++;
      if (act_r !== exp_r) begin
        bad++;
        $display("FAIL seq: got %b want %b (busy clr en mod done err q[4] sc[4]) t=%0t",
                 act_r, exp_r, $time);
      end
    end
  end

  initial begin
    int l;
    int h;
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    lo = '0; hi = '0; dwell = '0; n_sweeps = '0;
    m_q = 4'd0; m_sc = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {3'd0, busy}, 4'd0);
    check("reset_en", {3'd0, cnt_en}, 4'd0);
    check("reset_mod", {3'd0, mod}, 4'd1);
    check("reset_done_err", {2'd0, done, err}, 4'd0);
    check("reset_sc", sweep_cnt, 4'd0);
    rst = 1'b1;

    run(2, 5, 2, 1, 0, 0, 0);     // basic sweep
    run(0, 3, 0, 2, 0, 0, 0);     // zero dwell, two sweeps
    run(7, 7, 1, 1, 0, 0, 0);     // rejected config
    run(1, 4, 1, 0, 1, 3, 3);     // continuous, stop in DOWN at q=3 after 3 sweeps
    run(1, 6, 1, 1, 3, 0, 2);     // async reset in UP at q=2
    start_stop_idle();
    run(1, 10, 2, 2, 2, 0, 5);    // start + bound changes during UP
    run(0, 15, 1, 1, 0, 0, 0);    // top bound, no wrap

    for (int i = 0; i < 10; i++) begin
      l = $urandom_range(0, 14);
      h = $urandom_range(l + 1, 15);
      if ($urandom_range(0, 3) == 0) h = $urandom_range(0, l);
      run(l, h, $urandom_range(0, 3), $urandom_range(1, 3), 0, 0, 0);
    end
    run($urandom_range(0, 5), $urandom_range(8, 15), $urandom_range(0, 2), 0, 1, 1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
